// File: rtl/generic_fifo_ptr_ctrl.sv
// Pointer, level and full/empty bookkeeping for a small register-file FIFO.
// Write and free requests must already be qualified by the caller.
module generic_fifo_ptr_ctrl #(
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_flush,
    input  logic                 i_wr_en,
    input  logic                 i_free_en,
    output logic [PTR_WIDTH-1:0] o_wr_ptr,
    output logic [PTR_WIDTH-1:0] o_rd_ptr,
    output logic [PTR_WIDTH:0]   o_level,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam logic [PTR_WIDTH:0]   LEVEL_FULL = {1'b1, {PTR_WIDTH{1'b0}}};
    localparam logic [PTR_WIDTH:0]   LEVEL_ONE  = 1;
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = 1;

    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [PTR_WIDTH:0]   r_level;

    // Pointers wrap naturally because NUM_OF_ENTRIES is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_wr_en)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_free_en)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({i_wr_en, i_free_en})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_level  = r_level;
    assign o_full   = (r_level == LEVEL_FULL);
    assign o_empty  = (r_level == '0);

    a_level_bound: assert property (@(posedge clk) disable iff (!reset_n) r_level <= LEVEL_FULL);

endmodule

// File: rtl/generic_fifo_d2xxd_unpack.sv
// Width down-converter FIFO: buffers 2*DW-bit words and emits them as two DW-bit words.
// Handshakes: a beat moves on a port exactly when valid & ready are both high at the clock edge.
module generic_fifo_d2xxd_unpack #(
    parameter int PTR_WIDTH = 2,
    parameter int DW        = 10,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [2*DW-1:0]      wrdata,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DW-1:0]        rddata,
    output logic [PTR_WIDTH:0]   level
);

    localparam int NUM_OF_ENTRIES = 2**PTR_WIDTH;

    logic [2*DW-1:0]      r_mem [NUM_OF_ENTRIES];
    logic                 r_half;
    logic [PTR_WIDTH-1:0] w_wr_ptr;
    logic [PTR_WIDTH-1:0] w_rd_ptr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_en;
    logic                 w_rd_xfer;
    logic                 w_free;
    logic [2*DW-1:0]      w_entry;

    // Flush discards any write or read happening in the same cycle.
    assign w_wr_en   = wr_valid & wr_ready & ~flush;
    assign w_rd_xfer = rd_valid & rd_ready & ~flush;
    assign w_free    = w_rd_xfer & r_half;

    generic_fifo_ptr_ctrl #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_ptr_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (flush),
        .i_wr_en   (w_wr_en),
        .i_free_en (w_free),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_ptr  (w_rd_ptr),
        .o_level   (level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OF_ENTRIES; i++)
                r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_wr_ptr] <= wrdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_half <= 1'b0;
        else if (flush)
            r_half <= 1'b0;
        else if (w_rd_xfer)
            r_half <= ~r_half;
    end

    assign w_entry  = r_mem[w_rd_ptr];
    assign wr_ready = ~w_full;
    assign rd_valid = ~w_empty;

    // r_half=0 selects the half that goes out first for the configured order.
    always_comb begin
        rddata = w_entry[DW-1:0];
        if ((LSB_FIRST != 0) == r_half)
            rddata = w_entry[2*DW-1:DW];
    end

endmodule

// File: tb/tb_generic_fifo_d2xxd_unpack.sv
// Randomized scoreboard bench for the 2*DW to DW unpacking FIFO, plus an MSB-first instance.
module tb_generic_fifo_d2xxd_unpack;

    localparam int DW = 10;
    localparam int PW = 2;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [2*DW-1:0] wrdata;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rddata;
    logic [PW:0]   level;

    logic          m_flush;
    logic          m_wr_valid;
    logic          m_wr_ready;
    logic [2*DW-1:0] m_wrdata;
    logic          m_rd_valid;
    logic          m_rd_ready;
    logic [DW-1:0] m_rddata;
    logic [PW:0]   m_level;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    generic_fifo_d2xxd_unpack #(.PTR_WIDTH(PW), .DW(DW), .LSB_FIRST(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wrdata(wrdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rddata(rddata),
        .level(level)
    );

    generic_fifo_d2xxd_unpack #(.PTR_WIDTH(PW), .DW(DW), .LSB_FIRST(0)) u_dut_msb (
        .clk(clk), .reset_n(reset_n), .flush(m_flush),
        .wr_valid(m_wr_valid), .wr_ready(m_wr_ready), .wrdata(m_wrdata),
        .rd_valid(m_rd_valid), .rd_ready(m_rd_ready), .rddata(m_rddata),
        .level(m_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: the FIFO holds a sequence of narrow words; each accepted
    // wide word appends low then high half. Occupied wide entries = ceil(words/2).
    int   mon_lvl;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            mon_lvl = (exp_q.size() + 1) / 2;
            check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
            check("level", 32'(level), 32'(mon_lvl));
            check("wr_ready", 32'(wr_ready), 32'(mon_lvl != NE));
            if (prev_stall) begin
                check("stall_valid", 32'(rd_valid), 32'd1);
                check("stall_data", 32'(rddata), 32'(prev_data));
            end
            prev_stall = rd_valid && !rd_ready && !flush;
            prev_data  = rddata;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (rd_valid && rd_ready && exp_q.size() != 0)
                    check("rddata", 32'(rddata), 32'(exp_q.pop_front()));
                if (wr_valid && mon_lvl != NE) begin
                    exp_q.push_back(wrdata[DW-1:0]);
                    exp_q.push_back(wrdata[2*DW-1:DW]);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic write_word(input logic [2*DW-1:0] d);
        int t;
        wr_valid = 1'b1;
        wrdata   = d;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wr_ready && t < 200);
        if (!wr_ready)
            timeout_fail("write_accept");
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int t;
        rd_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((rd_valid || level != 0) && t < 200);
        if (rd_valid || level != 0)
            timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int t;
        bit wr_done;

        reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wrdata = '0;
        m_flush = 1'b0; m_wr_valid = 1'b0; m_rd_ready = 1'b0; m_wrdata = '0;
        #1;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_level", 32'(level), 32'd0);
        check("reset_rddata", 32'(rddata), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // MSB-first instance: upper half leaves first.
        @(posedge clk); #1;
        m_wr_valid = 1'b1;
        m_wrdata   = {10'h3FF, 10'h001};
        @(posedge clk); #1;
        m_wr_valid = 1'b0;
        @(negedge clk);
        check("msb_valid", 32'(m_rd_valid), 32'd1);
        check("msb_first", 32'(m_rddata), 32'h3FF);
        m_rd_ready = 1'b1;
        @(negedge clk);
        check("msb_second", 32'(m_rddata), 32'h001);
        check("msb_level_mid", 32'(m_level), 32'd1);
        @(negedge clk);
        check("msb_empty", 32'(m_rd_valid), 32'd0);
        check("msb_level_end", 32'(m_level), 32'd0);
        m_rd_ready = 1'b0;
        @(posedge clk); #1;

        // Streaming with continuous reads; eight words wrap the four entries.
        rd_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    write_word({10'(2 * k + 1), 10'(2 * k + 2)});
            end
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!rd_valid && t < 20);
                gaps = 0;
                repeat (15) begin
                    @(negedge clk);
                    if (!rd_valid) gaps++;
                end
                check("stream_gaps", 32'(gaps), 32'd0);
            end
        join
        wait_empty();

        // Full buffer and slot release only after the second half.
        rd_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            write_word(20'($urandom));
        wr_valid = 1'b1;
        wrdata   = 20'($urandom);
        @(negedge clk);
        check("full_level", 32'(level), 32'd4);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk); #1; rd_ready = 1'b1;
        @(posedge clk); #1; rd_ready = 1'b0;
        @(negedge clk);
        check("pulse1_level", 32'(level), 32'd4);
        check("pulse1_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk); #1; rd_ready = 1'b1;
        @(posedge clk); #1; rd_ready = 1'b0;
        @(negedge clk);
        check("pulse2_level", 32'(level), 32'd3);
        check("pulse2_wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk); #1; wr_valid = 1'b0;
        @(negedge clk);
        check("fifth_level", 32'(level), 32'd4);
        @(posedge clk); #1;
        wait_empty();

        // Random backpressure against random write gaps.
        wr_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    write_word(20'($urandom));
                end
                wr_done = 1'b1;
            end
            begin
                t = 0;
                while ((!wr_done || t < 100) && t < 3000) begin
                    rd_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    t++;
                end
            end
        join
        wait_empty();

        // Flush with half an entry consumed and three entries held.
        rd_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            write_word(20'($urandom));
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wrdata   = 20'($urandom);
        flush    = 1'b1;
        @(negedge clk);
        check("preflush_level", 32'(level), 32'd3);
        @(posedge clk); #1;
        flush = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        check("flush_level", 32'(level), 32'd0);
        check("flush_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        write_word({10'h2C3, 10'h13C});
        @(negedge clk);
        check("flush_next_low", 32'(rddata), 32'h13C);
        @(posedge clk); #1;
        wait_empty();

        // Asynchronous reset in the middle of traffic.
        rd_ready = 1'b0;
        write_word(20'($urandom));
        write_word(20'($urandom));
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_rddata", 32'(rddata), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b1;
        write_word({10'h2AB, 10'h155});
        @(negedge clk);
        check("post_rst_low", 32'(rddata), 32'h155);
        @(negedge clk);
        check("post_rst_high", 32'(rddata), 32'h2AB);
        @(posedge clk); #1;
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
